// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch resolve, multi-cycle word load/store
// on a local data memory with upstream stall, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int MEM_DEPTH   = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctlout,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] EX_MEM_NPC,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        PCSrc,
    output logic [31:0] branch_target,
    output logic        stall,
    output logic        align_err,
    output logic        regwrite,
    output logic        memtoreg,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       mem_q [MEM_DEPTH];

    logic              regwrite_q, memtoreg_q, align_err_q;
    logic [31:0]       read_data_q, alu_q;
    logic [4:0]        wreg_q;
    logic              regwrite_d;
    logic [31:0]       read_data_d;

    logic              mem_op, aligned, is_load, complete;
    logic [ADDR_W-1:0] word;

    assign PCSrc         = branch & zero;
    assign branch_target = EX_MEM_NPC;

    assign mem_op   = memread | memwrite;
    assign aligned  = (alu_result[1:0] == 2'b00);
    assign is_load  = memread & ~memwrite;
    assign word     = alu_result[ADDR_W+1:2];
    assign stall    = mem_op & aligned & (cnt_q != CNT_LAST);
    assign complete = mem_op & aligned & ~stall;

    // Misaligned ops bypass memory entirely and must not write back.
    always_comb begin
        regwrite_d  = wb_ctlout[1] & ~(mem_op & ~aligned);
        read_data_d = 32'h0;
        if (complete && is_load)
            read_data_d = mem_q[word];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            read_data_q <= 32'h0;
            alu_q       <= 32'h0;
            wreg_q      <= 5'd0;
            align_err_q <= 1'b0;
        end else if (stall) begin
            state_q     <= BUSY;
            cnt_q       <= cnt_q + 1'b1;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            read_data_q <= 32'h0;
            alu_q       <= 32'h0;
            wreg_q      <= 5'd0;
        end else begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= wb_ctlout[0];
            read_data_q <= read_data_d;
            alu_q       <= alu_result;
            wreg_q      <= five_bit_muxout;
            if (mem_op)
                align_err_q <= ~aligned;
        end
    end

    // Store commits once, on the completion edge; reset aborts it.
    always_ff @(posedge clk) begin
        if (!rst && complete && memwrite)
            mem_q[word] <= rdata2out;
    end

    assign regwrite       = regwrite_q;
    assign memtoreg       = memtoreg_q;
    assign read_data      = read_data_q;
    assign mem_alu_result = alu_q;
    assign mem_write_reg  = wreg_q;
    assign align_err      = align_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (MEM_LATENCY=2, MEM_DEPTH=256): stimulus queues the expected
// MEM/WB contents per edge, a monitor pops and compares after each rising edge.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_ctlout;
    logic        branch, memread, memwrite, zero;
    logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        PCSrc, stall, align_err, regwrite, memtoreg;
    logic [31:0] branch_target, read_data, mem_alu_result;
    logic [4:0]  mem_write_reg;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        aerr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_stage #(.MEM_DEPTH(256), .MEM_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .wb_ctlout(wb_ctlout), .branch(branch),
        .memread(memread), .memwrite(memwrite), .EX_MEM_NPC(EX_MEM_NPC),
        .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
        .five_bit_muxout(five_bit_muxout), .PCSrc(PCSrc),
        .branch_target(branch_target), .stall(stall), .align_err(align_err),
        .regwrite(regwrite), .memtoreg(memtoreg), .read_data(read_data),
        .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: MEM/WB is presented on every edge once stimulus has queued an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("regwrite",       32'(regwrite),       32'(e.rw));
                chk("memtoreg",       32'(memtoreg),       32'(e.mtr));
                chk("read_data",      read_data,           e.rd);
                chk("mem_alu_result", mem_alu_result,      e.alu);
                chk("mem_write_reg",  32'(mem_write_reg),  32'(e.wr));
                chk("align_err",      32'(align_err),      32'(e.aerr));
            end
        end
    end

    function automatic exp_t mk(input logic rw, input logic mtr, input logic [31:0] rd,
                                input logic [31:0] alu, input logic [4:0] wr, input logic aerr);
        mk = '{rw: rw, mtr: mtr, rd: rd, alu: alu, wr: wr, aerr: aerr};
    endfunction

    task automatic drive(input logic [1:0] wb, input logic mr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
        wb_ctlout = wb; memread = mr; memwrite = mw;
        alu_result = alu; rdata2out = wd; five_bit_muxout = wr;
        branch = 1'b0; zero = 1'b0; EX_MEM_NPC = 32'h0;
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic step(input string name, input logic exp_stall, input exp_t e);
        #1;
        chk(name, 32'(stall), 32'(exp_stall));
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        exp_t bub;
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        bub = mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        step("stall_rst0", 1'b0, bub);
        step("stall_rst1", 1'b0, bub);
        rst = 1'b0;

        // R-type passes straight through
        drive(2'b10, 1'b0, 1'b0, 32'h42, 32'h0, 5'd5);
        step("stall_rtype", 1'b0, mk(1'b1, 1'b0, 32'h0, 32'h42, 5'd5, 1'b0));

        // store then load of word 4
        drive(2'b00, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0);
        step("stall_st_c0", 1'b1, bub);
        step("stall_st_c1", 1'b0, mk(1'b0, 1'b0, 32'h0, 32'h10, 5'd0, 1'b0));
        drive(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7);
        step("stall_ld_c0", 1'b1, bub);
        step("stall_ld_c1", 1'b0, mk(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd7, 1'b0));

        // branch resolution is combinational
        drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        branch = 1'b1; zero = 1'b1; EX_MEM_NPC = 32'h0000_0100;
        #1;
        chk("PCSrc_taken", 32'(PCSrc), 32'd1);
        chk("branch_target", branch_target, 32'h100);
        zero = 1'b0;
        #1;
        chk("PCSrc_not_taken", 32'(PCSrc), 32'd0);
        step("stall_branch", 1'b0, bub);

        // misaligned load and store: no stall, no writeback, memory untouched
        drive(2'b11, 1'b1, 1'b0, 32'h13, 32'h0, 5'd3);
        step("stall_misal_ld", 1'b0, mk(1'b0, 1'b1, 32'h0, 32'h13, 5'd3, 1'b1));
        drive(2'b00, 1'b0, 1'b1, 32'h11, 32'h1234_5678, 5'd0);
        step("stall_misal_st", 1'b0, mk(1'b0, 1'b0, 32'h0, 32'h11, 5'd0, 1'b1));
        drive(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
        step("stall_realign_c0", 1'b1, mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b1));
        step("stall_realign_c1", 1'b0, mk(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h10, 5'd3, 1'b0));

        // reset aborts an in-flight store
        drive(2'b00, 1'b0, 1'b1, 32'h20, 32'h0000_5555, 5'd0);
        step("stall_st20_c0", 1'b1, bub);
        step("stall_st20_c1", 1'b0, mk(1'b0, 1'b0, 32'h0, 32'h20, 5'd0, 1'b0));
        drive(2'b00, 1'b0, 1'b1, 32'h20, 32'h0000_0BAD, 5'd0);
        step("stall_abort_c0", 1'b1, bub);
        rst = 1'b1;
        step("stall_abort_rst", 1'b0, bub);
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step("stall_after_rst", 1'b0, bub);
        drive(2'b11, 1'b1, 1'b0, 32'h20, 32'h0, 5'd9);
        step("stall_ld20_c0", 1'b1, bub);
        step("stall_ld20_c1", 1'b0, mk(1'b1, 1'b1, 32'h0000_5555, 32'h20, 5'd9, 1'b0));

        // address wrap, then read+write treated as store
        drive(2'b00, 1'b0, 1'b1, 32'h400, 32'h1, 5'd0);
        step("stall_wrap_c0", 1'b1, bub);
        step("stall_wrap_c1", 1'b0, mk(1'b0, 1'b0, 32'h0, 32'h400, 5'd0, 1'b0));
        drive(2'b11, 1'b1, 1'b0, 32'h0, 32'h0, 5'd4);
        step("stall_ld0_c0", 1'b1, bub);
        step("stall_ld0_c1", 1'b0, mk(1'b1, 1'b1, 32'h1, 32'h0, 5'd4, 1'b0));
        drive(2'b11, 1'b1, 1'b1, 32'h8, 32'h0000_CAFE, 5'd6);
        step("stall_rw_c0", 1'b1, bub);
        step("stall_rw_c1", 1'b0, mk(1'b1, 1'b1, 32'h0, 32'h8, 5'd6, 1'b0));
        drive(2'b11, 1'b1, 1'b0, 32'h8, 32'h0, 5'd6);
        step("stall_ld8_c0", 1'b1, bub);
        step("stall_ld8_c1", 1'b0, mk(1'b1, 1'b1, 32'h0000_CAFE, 32'h8, 5'd6, 1'b0));

        drive(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
